// File: rtl/issue_pair_sched.sv
// Dual-issue scheduler: buffers instruction pairs in a FIFO and offers the
// head one or two instructions per cycle, falling back to single issue when
// the head pair has a structural, control or register hazard.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_instr0/in_instr1/in_ready    pair producer handshake
//   flush                       discard all buffered instructions
//   issue_valid0/issue_instr0   slot 0 (buffer head)
//   issue_valid1/issue_instr1   slot 1 (head+1), valid only when pairable
//   issue_ready                 backend accepts the offered issue group
//   pair_cnt/single_cnt         wrapping counts of dual/single issue groups
module issue_pair_sched #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_instr0,
    input  logic [31:0] in_instr1,
    output logic        in_ready,
    input  logic        flush,
    output logic        issue_valid0,
    output logic [31:0] issue_instr0,
    output logic        issue_valid1,
    output logic [31:0] issue_instr1,
    input  logic        issue_ready,
    output logic [15:0] pair_cnt,
    output logic [15:0] single_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_S_TYPE = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_B_TYPE = 7'b1100011;
    localparam logic [6:0] OP_I_IMME = 7'b0010011;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;

    typedef struct packed {
        logic       wr;      // writes a nonzero rd
        logic [4:0] rd;
        logic       use_rs1;
        logic       use_rs2;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       mem;     // occupies the single memory port
        logic       ctrl;    // control transfer
        logic       unk;     // unrecognised opcode
    } dec_t;

    // Register usage and class of one instruction; x0 reads are masked so
    // they can never match a writer.
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d = '0;
        d.rd  = ins[11:7];
        d.rs1 = ins[19:15];
        d.rs2 = ins[24:20];
        case (ins[6:0])
            OP_LOAD:   begin d.wr = 1'b1; d.use_rs1 = 1'b1; d.mem = 1'b1; end
            OP_S_TYPE: begin d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.mem = 1'b1; end
            OP_JAL:    begin d.wr = 1'b1; d.ctrl = 1'b1; end
            OP_B_TYPE: begin d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.ctrl = 1'b1; end
            OP_I_IMME: begin d.wr = 1'b1; d.use_rs1 = 1'b1; end
            OP_R_TYPE: begin d.wr = 1'b1; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
            default:   d.unk = 1'b1;
        endcase
        d.wr      = d.wr && (d.rd != 5'd0);
        d.use_rs1 = d.use_rs1 && (d.rs1 != 5'd0);
        d.use_rs2 = d.use_rs2 && (d.rs2 != 5'd0);
        return d;
    endfunction

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    dec_t          d0;
    dec_t          d1;
    logic          raw;
    logic          waw;
    logic          blocked;
    logic          push;
    logic          pop;
    logic          pop_two;

    // Issue view straight from buffer head and count
    assign issue_instr0 = mem[rd_ptr];
    assign issue_instr1 = mem[rd_ptr + PW'(1)];
    assign issue_valid0 = (count != CW'(0));
    assign in_ready     = (count <= CW'(DEPTH - 2)) && !flush;

    // Pairing blockers for the head pair
    always_comb begin
        d0      = decode(issue_instr0);
        d1      = decode(issue_instr1);
        raw     = d0.wr && ((d1.use_rs1 && (d1.rs1 == d0.rd)) ||
                            (d1.use_rs2 && (d1.rs2 == d0.rd)));
        waw     = d0.wr && d1.wr && (d0.rd == d1.rd);
        blocked = d0.ctrl || (d0.mem && d1.mem) || raw || waw || d0.unk || d1.unk;
    end

    assign issue_valid1 = (count >= CW'(2)) && !blocked;

    // Handshakes and next occupancy
    always_comb begin
        push       = in_valid && in_ready;
        pop        = issue_valid0 && issue_ready;
        pop_two    = pop && issue_valid1;
        count_next = count;
        if (push) count_next = count_next + CW'(2);
        if (pop)  count_next = count_next - (pop_two ? CW'(2) : CW'(1));
    end

    // Pointer, occupancy and statistics state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            pair_cnt   <= '0;
            single_cnt <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (push) wr_ptr <= wr_ptr + PW'(2);
            if (pop) begin
                rd_ptr <= rd_ptr + (pop_two ? PW'(2) : PW'(1));
                if (pop_two) pair_cnt   <= pair_cnt + 16'd1;
                else         single_cnt <= single_cnt + 16'd1;
            end
        end
    end

    // Buffer storage, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]          <= in_instr0;
            mem[wr_ptr + PW'(1)] <= in_instr1;
        end
    end

endmodule

// File: tb/tb_issue_pair_sched.sv
// Directed bench for issue_pair_sched (DEPTH=4): pairing rules, stall and
// back-pressure, flush and reset-during-stall.
module tb_issue_pair_sched;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr0;
    logic [31:0] in_instr1;
    logic        in_ready;
    logic        flush;
    logic        issue_valid0;
    logic [31:0] issue_instr0;
    logic        issue_valid1;
    logic [31:0] issue_instr1;
    logic        issue_ready;
    logic [15:0] pair_cnt;
    logic [15:0] single_cnt;

    int n_vec;
    int n_err;
    int exp_pair;
    int exp_single;

    localparam logic [31:0] ADD_X5   = 32'h002082B3; // add  x5,x1,x2
    localparam logic [31:0] ADDI_X6  = 32'h00118313; // addi x6,x3,1
    localparam logic [31:0] ADD_X7   = 32'h004283B3; // add  x7,x5,x4
    localparam logic [31:0] LW_X10   = 32'h0000A503; // lw   x10,0(x1)
    localparam logic [31:0] SW_X11   = 32'h00B12023; // sw   x11,0(x2)
    localparam logic [31:0] BEQ      = 32'h00208063; // beq  x1,x2,0
    localparam logic [31:0] ADDI_X0  = 32'h00100013; // addi x0,x0,1
    localparam logic [31:0] ADD_X8_0 = 32'h00000433; // add  x8,x0,x0
    localparam logic [31:0] ADDI_X5  = 32'h00118293; // addi x5,x3,1
    localparam logic [31:0] JAL_X1   = 32'h000000EF; // jal  x1,0
    localparam logic [31:0] BAD_OP   = 32'hFFFFFFFF;

    issue_pair_sched #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_instr0(in_instr0), .in_instr1(in_instr1),
        .in_ready(in_ready), .flush(flush),
        .issue_valid0(issue_valid0), .issue_instr0(issue_instr0),
        .issue_valid1(issue_valid1), .issue_instr1(issue_instr1),
        .issue_ready(issue_ready),
        .pair_cnt(pair_cnt), .single_cnt(single_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [31:0] i0, input logic [31:0] i1);
        in_valid = 1'b1; in_instr0 = i0; in_instr1 = i1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; issue_ready = 1'b0;
        in_instr0 = '0; in_instr1 = '0;
        step(); step();
        rst_n = 1'b1;
        #1;
        n_vec++; if (issue_valid0 !== 1'b0) begin n_err++; $display("FAIL reset_v0 got %b want 0", issue_valid0); end
        n_vec++; if (issue_valid1 !== 1'b0) begin n_err++; $display("FAIL reset_v1 got %b want 0", issue_valid1); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_rdy got %b want 1", in_ready); end
        n_vec++; if (pair_cnt !== 16'd0) begin n_err++; $display("FAIL reset_pair got %0d want 0", pair_cnt); end
        n_vec++; if (single_cnt !== 16'd0) begin n_err++; $display("FAIL reset_single got %0d want 0", single_cnt); end
        exp_pair = 0; exp_single = 0;
    endtask

    // Push one pair into an empty buffer while stalled, check the offer, then
    // drain it and check group counts and order.
    task automatic test_pair(input string nm, input logic [31:0] i0,
                             input logic [31:0] i1, input logic dual);
        issue_ready = 1'b0;
        push_pair(i0, i1);
        n_vec++; if (issue_valid0 !== 1'b1) begin n_err++; $display("FAIL %s_v0 got %b want 1", nm, issue_valid0); end
        n_vec++; if (issue_instr0 !== i0) begin n_err++; $display("FAIL %s_i0 got %h want %h", nm, issue_instr0, i0); end
        n_vec++; if (issue_instr1 !== i1) begin n_err++; $display("FAIL %s_i1 got %h want %h", nm, issue_instr1, i1); end
        n_vec++; if (issue_valid1 !== dual) begin n_err++; $display("FAIL %s_v1 got %b want %b", nm, issue_valid1, dual); end
        issue_ready = 1'b1;
        step();
        if (dual) begin
            exp_pair++;
        end else begin
            exp_single++;
            n_vec++; if (issue_instr0 !== i1 || issue_valid0 !== 1'b1 || issue_valid1 !== 1'b0) begin
                n_err++; $display("FAIL %s_second got v0=%b v1=%b i0=%h want v0=1 v1=0 i0=%h", nm, issue_valid0, issue_valid1, issue_instr0, i1);
            end
            step();
            exp_single++;
        end
        issue_ready = 1'b0;
        n_vec++; if (issue_valid0 !== 1'b0) begin n_err++; $display("FAIL %s_empty got %b want 0", nm, issue_valid0); end
        n_vec++; if (pair_cnt !== 16'(exp_pair)) begin n_err++; $display("FAIL %s_pair got %0d want %0d", nm, pair_cnt, exp_pair); end
        n_vec++; if (single_cnt !== 16'(exp_single)) begin n_err++; $display("FAIL %s_single got %0d want %0d", nm, single_cnt, exp_single); end
    endtask

    task automatic test_back_to_back();
        issue_ready = 1'b0;
        push_pair(ADD_X5, ADDI_X6);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_rdy2 got %b want 1", in_ready); end
        push_pair(ADDI_X0, ADD_X8_0);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_rdy4 got %b want 0", in_ready); end
        push_pair(BAD_OP, BAD_OP); // refused: buffer full
        n_vec++; if (issue_instr0 !== ADD_X5 || issue_instr1 !== ADDI_X6 || issue_valid1 !== 1'b1) begin
            n_err++; $display("FAIL stall_hold got i0=%h i1=%h v1=%b want %h %h 1", issue_instr0, issue_instr1, issue_valid1, ADD_X5, ADDI_X6);
        end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_full got %b want 0", in_ready); end
        issue_ready = 1'b1;
        step(); exp_pair++;
        n_vec++; if (issue_instr0 !== ADDI_X0 || issue_instr1 !== ADD_X8_0 || issue_valid1 !== 1'b1) begin
            n_err++; $display("FAIL drain_head got i0=%h i1=%h v1=%b want %h %h 1", issue_instr0, issue_instr1, issue_valid1, ADDI_X0, ADD_X8_0);
        end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL drain_rdy got %b want 1", in_ready); end
        step(); exp_pair++;
        issue_ready = 1'b0;
        n_vec++; if (issue_valid0 !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b want 0", issue_valid0); end
        n_vec++; if (pair_cnt !== 16'(exp_pair)) begin n_err++; $display("FAIL drain_pair got %0d want %0d", pair_cnt, exp_pair); end
    endtask

    task automatic test_flush();
        issue_ready = 1'b0;
        push_pair(ADD_X5, ADD_X7);
        // push and single pop at the same edge leaves three entries
        issue_ready = 1'b1;
        push_pair(ADDI_X6, ADD_X5);
        issue_ready = 1'b0;
        exp_single++;
        n_vec++; if (issue_instr0 !== ADD_X7 || issue_instr1 !== ADDI_X6 || issue_valid1 !== 1'b1) begin
            n_err++; $display("FAIL flush_pre got i0=%h i1=%h v1=%b want %h %h 1", issue_instr0, issue_instr1, issue_valid1, ADD_X7, ADDI_X6);
        end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_cnt3 got %b want 0", in_ready); end
        flush = 1'b1; in_valid = 1'b1; issue_ready = 1'b1;
        in_instr0 = BAD_OP; in_instr1 = BAD_OP;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_rdy got %b want 0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0; issue_ready = 1'b0;
        #1;
        n_vec++; if (issue_valid0 !== 1'b0 || issue_valid1 !== 1'b0) begin n_err++; $display("FAIL flush_v got v0=%b v1=%b want 0 0", issue_valid0, issue_valid1); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_rdy_after got %b want 1", in_ready); end
        n_vec++; if (pair_cnt !== 16'(exp_pair) || single_cnt !== 16'(exp_single)) begin
            n_err++; $display("FAIL flush_cnt got %0d/%0d want %0d/%0d", pair_cnt, single_cnt, exp_pair, exp_single);
        end
    endtask

    task automatic test_reset_stall();
        issue_ready = 1'b0;
        push_pair(LW_X10, SW_X11);
        push_pair(ADD_X5, ADDI_X6);
        n_vec++; if (in_ready !== 1'b0 || issue_valid0 !== 1'b1) begin n_err++; $display("FAIL rst4_pre got rdy=%b v0=%b want 0 1", in_ready, issue_valid0); end
        rst_n = 1'b0; issue_ready = 1'b1; in_valid = 1'b1;
        in_instr0 = ADD_X5; in_instr1 = ADDI_X6;
        step();
        in_valid = 1'b0; issue_ready = 1'b0;
        exp_pair = 0; exp_single = 0;
        n_vec++; if (issue_valid0 !== 1'b0) begin n_err++; $display("FAIL rst4_v0 got %b want 0", issue_valid0); end
        n_vec++; if (pair_cnt !== 16'd0 || single_cnt !== 16'd0) begin n_err++; $display("FAIL rst4_cnt got %0d/%0d want 0/0", pair_cnt, single_cnt); end
        rst_n = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst4_rdy got %b want 1", in_ready); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        test_reset();
        test_pair("dual",    ADD_X5,  ADDI_X6,  1'b1);
        test_pair("raw",     ADD_X5,  ADD_X7,   1'b0);
        test_pair("ldst",    LW_X10,  SW_X11,   1'b0);
        test_pair("branch",  BEQ,     ADD_X5,   1'b0);
        test_pair("x0",      ADDI_X0, ADD_X8_0, 1'b1);
        test_pair("waw",     ADD_X5,  ADDI_X5,  1'b0);
        test_pair("jal",     JAL_X1,  ADDI_X6,  1'b0);
        test_pair("unknown", ADD_X5,  BAD_OP,   1'b0);
        test_pair("ld_alu",  LW_X10,  ADDI_X6,  1'b1);
        test_back_to_back();
        test_flush();
        test_reset_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/issue_pair_sched.md
ISSUE_PAIR_SCHED -- requirements
Module: issue_pair_sched

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, instruction-buffer entries (power of two, >=4).
REQ-002 The block SHALL have one clock, clk; reset is synchronous and active-low, rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  producer offers an instruction pair this cycle.
REQ-006 in_instr0  input  32  older instruction of offered pair.
REQ-007 in_instr1  input  32  younger instruction of offered pair.
REQ-008 in_ready  output  1  buffer can accept a pair.
REQ-009 flush  input  1  discard all buffered instructions.
REQ-010 issue_valid0  output  1  slot 0 holds an issuable instruction.
REQ-011 issue_instr0  output  32  slot 0 instruction (buffer head).
REQ-012 issue_valid1  output  1  slot 1 issues together with slot 0.
REQ-013 issue_instr1  output  32  slot 1 instruction (head+1).
REQ-014 issue_ready  input  1  backend accepts the offered issue group.
REQ-015 pair_cnt  output  16  count of dual-issue groups.
REQ-016 single_cnt  output  16  count of single-issue groups.

Function
REQ-017 Opcode classes (bits[6:0]): LOAD 0000011, S_TYPE 0100011, JAL 1101111, B_TYPE 1100011, I_IMME 0010011, R_TYPE 0110011; any other value is UNKNOWN.
REQ-018 Writes rd: LOAD, I_IMME, R_TYPE, JAL, only when rd (bits[11:7]) != 0.
REQ-019 Reads rs1 (bits[19:15]): LOAD, S_TYPE, B_TYPE, I_IMME, R_TYPE; reads rs2 (bits[24:20]): S_TYPE, B_TYPE, R_TYPE; reads of x0 never create hazards.
REQ-020 Buffer SHALL be a FIFO with count register 0..DEPTH; in_instr0 stored ahead of in_instr1.
REQ-021 in_ready SHALL be 1 iff registered count <= DEPTH-2 and flush = 0.
REQ-022 Push of both instructions SHALL occur at the edge where in_valid & in_ready; pushed head visible on issue outputs the following cycle (1-cycle latency).
REQ-023 issue_valid0 SHALL be 1 iff count >= 1; issue outputs SHALL be combinational from buffer and count.
REQ-024 issue_valid1 SHALL be 1 iff count >= 2 and no pairing blocker holds.
REQ-025 Pairing blockers: slot0 is JAL or B_TYPE; both slots LOAD/S_TYPE (one memory port); slot0 writes rd equal to an rs read by slot1 (RAW); slot0 and slot1 write the same nonzero rd (WAW); either slot UNKNOWN.
REQ-026 When issue_valid1 = 0, issue_instr1 SHALL still show head+1 contents (don't-care to consumer).
REQ-027 On issue_valid0 & issue_ready, buffer SHALL pop 2 entries if issue_valid1 else 1.
REQ-028 Issue outputs SHALL hold stable while issue_valid0 & !issue_ready (no pop).
REQ-029 Simultaneous push and pop SHALL be allowed: count_next = count + 2*push - pops.
REQ-030 pair_cnt increments on each 2-entry pop, single_cnt on each 1-entry pop; both wrap 0xFFFF -> 0x0000.
REQ-031 flush SHALL set count to 0 and read/write pointers to 0 at the edge; flush overrides push and pop that cycle; counters not incremented that cycle.
REQ-032 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-033 With rst_n = 0 at an edge: count, pointers, pair_cnt, single_cnt -> 0; hence issue_valid0 = issue_valid1 = 0, in_ready = 1 after release.
REQ-034 Reset SHALL override flush, push and pop, including mid-stall; buffer contents need not clear.

Verification
REQ-035 Pair R_TYPE x5=x1+x2 (0x002082B3), I_IMME x6=x3+1 (0x00118313), issue_ready=1 -> next cycle issue_valid0=issue_valid1=1, pop 2, pair_cnt=1.
REQ-036 Pair 0x002082B3 then R_TYPE x7=x5+x4 (0x004283B3) -> issue_valid1=0 (RAW); single issue twice, single_cnt=2, issue order preserved.
REQ-037 Pair LOAD then S_TYPE, and pair B_TYPE then R_TYPE -> each issues singly; pair with rd=x0 writer followed by x0 reader -> dual issue.
REQ-038 Hold issue_ready=0, push 2 pairs (DEPTH=4) -> in_ready=0, outputs stable; push ignored while in_ready=0; release -> drains in order, pointers wrap correctly.
REQ-039 Buffer count 3, assert flush with in_valid=1 -> next cycle count 0, issue_valid0=0, counters unchanged.
REQ-040 Assert rst_n=0 during stall with count 4 -> next cycle all counters 0, issue_valid0=0, in_ready=1 after release.
